joypad_port: RTL
================

JOYPAD_PORT -- requirements
Module: joypad_port

Interface
REQ-001 The module SHALL have the port: clk  in  1  system clock; every register samples on the rising edge.
REQ-002 The module SHALL have the port: nres  in  1  reset, asynchronous and active-low.
REQ-003 The module SHALL have the port: key_valid  in  1  one-cycle pulse; keyCode and press are valid in that cycle.
REQ-004 The module SHALL have the port: keyCode  in  8  PS/2 set-2 make code, extended prefix already stripped.
REQ-005 The module SHALL have the port: press  in  1  1 = key went down, 0 = key released.
REQ-006 The module SHALL have the port: cs  in  1  one-cycle CPU access strobe for address $4016.
REQ-007 The module SHALL have the port: we  in  1  1 = write access, 0 = read access; qualified by cs.
REQ-008 The module SHALL have the port: wdata  in  8  CPU write data; only bit 0 is used.
REQ-009 The module SHALL have the port: rdata  out  8  CPU read data, registered.
REQ-010 The module SHALL have the port: keystates  out  8  live button state, for the HEX display.

Function
REQ-011 keystates bit map SHALL be: 0 A=K(0x42), 1 B=J(0x3B), 2 Select=G(0x34), 3 Start=H(0x33), 4 Up=W(0x1D), 5 Down=S(0x1B), 6 Left=A(0x1C), 7 Right=D(0x23).
REQ-012 On key_valid with a mapped keyCode, the mapped keystates bit SHALL take the value of press at the next edge; all other bits SHALL hold.
REQ-013 An unmapped keyCode, or key_valid=0, SHALL leave keystates unchanged.
REQ-014 On cs=1 and we=1, the strobe register SHALL load wdata[0] at that edge.
REQ-015 The module SHALL implement the states LOAD (strobe=1), SHIFT (strobe=0 with bit count 0..7) and DRAINED (strobe=0 with bit count 8).
REQ-016 In LOAD, the 8-bit shift register SHALL reload from the registered keystates value every cycle, and the bit count SHALL be 0.
REQ-017 A strobe write of 0 SHALL move the block to SHIFT; the shift register SHALL keep the value loaded at the final LOAD edge.
REQ-018 A strobe write of 1 from any state SHALL move the block to LOAD at the next edge.
REQ-019 A read (cs=1, we=0) in LOAD SHALL set rdata to {7'b0100000, keystates[0]}; it SHALL NOT shift and SHALL NOT count.
REQ-020 A read in SHIFT SHALL set rdata to {7'b0100000, shift[0]}, shift the register right with 1 inserted at bit 7, and increment the count.
REQ-021 The eighth read SHALL move the block to DRAINED.
REQ-022 A read in DRAINED SHALL set rdata to 8'h41; the count SHALL saturate at 8.
REQ-023 Read latency SHALL be one edge: rdata changes only on the edge that samples a read, and holds its value until the next read.
REQ-024 A write SHALL NOT change rdata.
REQ-025 When key_valid coincides with LOAD, the shift register SHALL load the pre-update keystates; the new value SHALL appear one cycle later.
REQ-026 A cs pulse longer than one cycle SHALL be treated as one access per cycle; the CPU side guarantees single-cycle pulses.

Reset
REQ-027 nres=0 SHALL asynchronously clear keystates to 8'h00, strobe to 0, the shift register to 8'h00, the count to 8 (state DRAINED), and rdata to 8'h40.
REQ-028 Reset asserted mid-sequence SHALL abort it; after release, reads SHALL return 8'h41 until the next strobe write.
REQ-029 Deassertion of nres SHALL take effect on the first rising clk edge after release.

Verification
REQ-030 The bench SHALL cover: press K, J and D (key_valid pulses, press=1) -> keystates=8'h83.
REQ-031 The bench SHALL cover: with keystates=8'h83, write 1 then write 0, then 10 reads -> rdata sequence 41,41,40,40,40,40,40,41,41,41.
REQ-032 The bench SHALL cover: strobe=1, three reads with A held -> each read returns 8'h41, and reads after the subsequent write of 0 still start at bit 0.
REQ-033 The bench SHALL cover: release K (press=0, keyCode=0x42) in the same cycle as the final LOAD edge -> the shifted-out first bit is 1 and keystates=8'h82 afterwards.
REQ-034 The bench SHALL cover: unmapped keyCode 0x15 with press=1 -> keystates unchanged.
REQ-035 The bench SHALL cover: nres pulsed low after 3 reads of a sequence -> rdata=8'h40 immediately, keystates=8'h00, and the next read returns 8'h41.

Source files
------------

// File: rtl/joypad_port.sv
// -----------------------------------------------------------------------------
// joypad_port
// Keyboard-driven NES-style controller port at CPU address $4016.
//
// PS/2 make/break events update an 8-bit live button map (keystates). The CPU
// writes bit 0 to the strobe register. While the strobe is 1 the shift register
// continuously reloads from the button map. Once the strobe drops to 0, each
// read returns one button bit, LSB first. After eight reads, every further read
// returns 1, as on the real controller.
//
// Ports
//   clk        in   system clock, rising-edge
//   nres       in   asynchronous active-low reset
//   key_valid  in   one-cycle pulse qualifying keyCode/press
//   keyCode    in   [7:0] PS/2 set-2 make code (extended prefix stripped)
//   press      in   1 = key down, 0 = key released
//   cs         in   one-cycle CPU access strobe for $4016
//   we         in   1 = write, 0 = read (qualified by cs)
//   wdata      in   [7:0] CPU write data, bit 0 is the strobe
//   rdata      out  [7:0] registered CPU read data
//   keystates  out  [7:0] live button map
// -----------------------------------------------------------------------------
module joypad_port (
    input  logic       clk,
    input  logic       nres,
    input  logic       key_valid,
    input  logic [7:0] keyCode,
    input  logic       press,
    input  logic       cs,
    input  logic       we,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic [7:0] keystates
);

    // Button bit i is driven by make code KEY_CODES[8*i +: 8].
    // Order: A=K, B=J, Select=G, Start=H, Up=W, Down=S, Left=A, Right=D.
    localparam logic [63:0] KEY_CODES = {8'h23, 8'h1C, 8'h1B, 8'h1D,
                                         8'h33, 8'h34, 8'h3B, 8'h42};

    // LOAD is the strobe register holding 1.
    // SHIFT and DRAINED are strobe = 0 with count < 8 and count = 8 respectively.
    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_DRAINED = 2'd2
    } state_t;

    state_t     state_q;
    logic [7:0] keys_q;
    logic [7:0] shift_q;
    logic [3:0] count_q;
    logic [7:0] rdata_q;
    logic [7:0] key_hit;

    logic rd_access;
    logic wr_access;
    logic wdata_unused;

    assign rd_access    = cs & ~we;
    assign wr_access    = cs & we;
    assign wdata_unused = ^wdata[7:1];

    // One comparator per button. At most one bit can match a given code.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_key_match
            assign key_hit[gi] = key_valid && (keyCode == KEY_CODES[8*gi +: 8]);
        end
    endgenerate

    // Button map: matched bit takes press, all others hold.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            keys_q <= 8'h00;
        end else begin
            keys_q <= (keys_q & ~key_hit) | ({8{press}} & key_hit);
        end
    end

    // Strobe / shift FSM together with its datapath and the registered read port.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            state_q <= ST_DRAINED;
            shift_q <= 8'h00;
            count_q <= 4'd8;
            rdata_q <= 8'h40;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    // Reload from the registered map every cycle, including the
                    // edge that drops the strobe. A key event in that same cycle
                    // therefore shows up only from the next load onwards.
                    shift_q <= keys_q;
                    count_q <= 4'd0;
                    if (rd_access) begin
                        rdata_q <= {7'b0100000, keys_q[0]};
                    end
                    if (wr_access && !wdata[0]) begin
                        state_q <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (wr_access) begin
                        if (wdata[0]) begin
                            state_q <= ST_LOAD;
                            count_q <= 4'd0;
                        end
                    end else if (rd_access) begin
                        rdata_q <= {7'b0100000, shift_q[0]};
                        shift_q <= {1'b1, shift_q[7:1]};
                        count_q <= count_q + 4'd1;
                        if (count_q == 4'd7) begin
                            state_q <= ST_DRAINED;
                        end
                    end
                end

                ST_DRAINED: begin
                    if (wr_access) begin
                        if (wdata[0]) begin
                            state_q <= ST_LOAD;
                            count_q <= 4'd0;
                        end
                    end else if (rd_access) begin
                        // Count stays saturated at 8.
                        rdata_q <= 8'h41;
                    end
                end

                default: begin
                    state_q <= ST_DRAINED;
                    count_q <= 4'd8;
                end
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign keystates = keys_q;

endmodule
